// File: rtl/uart_calc_parser.sv
// rtl/uart_calc_parser.sv - parses "A<op>B=" from the UART receiver and streams the ASCII result plus CR LF
module uart_calc_parser #(
  parameter int DATA_W     = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun
);

  localparam int AW = DATA_W + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int PW = $clog2(MAX_DIGITS + 1);
  localparam int IW = $clog2(MAX_DIGITS + 3);
  localparam int LW = IW + 1;
  localparam logic [AW-1:0] MAX_VAL = {4'b0000, {DATA_W{1'b1}}};

  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  typedef enum logic [2:0] {S_ACC_A, S_ACC_B, S_ERR, S_CALC, S_CONV, S_SEND} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t              state;
  op_t                 op;
  logic [DATA_W-1:0]   a_reg, b_reg, rem;
  logic [CW-1:0]       cnt_a, cnt_b;
  logic [PW-1:0]       pidx;
  logic [3:0]          dig;
  logic                started;
  logic [LW-1:0]       len, idx;
  logic [7:0]          out_buf [2**IW];

  function automatic logic [DATA_W-1:0] pow10(input logic [PW-1:0] k);
    logic [DATA_W-1:0] p;
    p = 1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < int'(k)) p = p * DATA_W'(10);
    end
    return p;
  endfunction

  logic                is_digit, is_op, is_eq, is_space, acc_bad, err_emit;
  logic [DATA_W-1:0]   cur;
  logic [CW-1:0]       cur_cnt;
  logic [AW-1:0]       acc_next;
  logic [DATA_W:0]     sum_w;
  logic [2*DATA_W-1:0] prod_w;
  logic [DATA_W-1:0]   p_cur, calc_res;
  logic                calc_err, calc_neg;
  logic [IW-1:0]       li;
  logic [7:0]          dig_ch;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_op    = (rx_data == 8'h2B) || (rx_data == 8'h2D) || (rx_data == 8'h2A);
  assign is_eq    = (rx_data == 8'h3D);
  assign is_space = (rx_data == 8'h20);
  assign cur      = (state == S_ACC_B) ? b_reg : a_reg;
  assign cur_cnt  = (state == S_ACC_B) ? cnt_b : cnt_a;
  // Accumulate with 4 spare bits so an out-of-range operand is caught, never wrapped
  assign acc_next = {4'b0000, cur} * AW'(10) + {{(AW-4){1'b0}}, rx_data[3:0]};
  assign acc_bad  = (acc_next > MAX_VAL) || (cur_cnt == CW'(MAX_DIGITS));
  // An '=' that is itself an error terminates the expression, so "E" goes out immediately
  assign err_emit = rx_valid && is_eq &&
                    ((state == S_ERR) || (state == S_ACC_A) ||
                     ((state == S_ACC_B) && (cnt_b == '0)));
  assign sum_w    = {1'b0, a_reg} + {1'b0, b_reg};
  assign prod_w   = {{DATA_W{1'b0}}, a_reg} * {{DATA_W{1'b0}}, b_reg};
  assign p_cur    = pow10(pidx);
  assign li       = len[IW-1:0];
  assign dig_ch   = CH_ZERO + {4'b0000, dig};

  always_comb begin
    calc_err = 1'b0;
    calc_neg = 1'b0;
    calc_res = '0;
    case (op)
      OP_ADD: begin
        calc_err = sum_w[DATA_W];
        calc_res = sum_w[DATA_W-1:0];
      end
      OP_SUB: begin
        if (a_reg >= b_reg) begin
          calc_res = a_reg - b_reg;
        end else begin
          calc_neg = 1'b1;
          calc_res = b_reg - a_reg;
        end
      end
      OP_MUL: begin
        calc_err = |prod_w[2*DATA_W-1:DATA_W];
        calc_res = prod_w[DATA_W-1:0];
      end
      default: calc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_ACC_A;
      op       <= OP_ADD;
      a_reg    <= '0;
      b_reg    <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      rem      <= '0;
      pidx     <= '0;
      dig      <= '0;
      started  <= 1'b0;
      len      <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= rx_valid & busy;
      case (state)
        S_ACC_A, S_ACC_B, S_ERR: begin
          if (err_emit) begin
            out_buf[0] <= CH_E;
            out_buf[1] <= CH_CR;
            out_buf[2] <= CH_LF;
            len        <= LW'(3);
            idx        <= '0;
            busy       <= 1'b1;
            state      <= S_SEND;
          end else if (rx_valid && state == S_ACC_A) begin
            if (is_digit) begin
              if (acc_bad) state <= S_ERR;
              else begin
                a_reg <= acc_next[DATA_W-1:0];
                cnt_a <= cnt_a + CW'(1);
              end
            end else if (is_op) begin
              if (cnt_a != '0) begin
                op    <= (rx_data == 8'h2B) ? OP_ADD : (rx_data == 8'h2D) ? OP_SUB : OP_MUL;
                state <= S_ACC_B;
              end else state <= S_ERR;
            end else if (!is_space) state <= S_ERR;
          end else if (rx_valid && state == S_ACC_B) begin
            if (is_digit) begin
              if (acc_bad) state <= S_ERR;
              else begin
                b_reg <= acc_next[DATA_W-1:0];
                cnt_b <= cnt_b + CW'(1);
              end
            end else if (is_eq) begin
              busy  <= 1'b1;
              state <= S_CALC;
            end else if (!is_space) state <= S_ERR;
          end
        end
        S_CALC: begin
          idx <= '0;
          if (calc_err) begin
            out_buf[0] <= CH_E;
            out_buf[1] <= CH_CR;
            out_buf[2] <= CH_LF;
            len        <= LW'(3);
            state      <= S_SEND;
          end else begin
            rem        <= calc_res;
            out_buf[0] <= CH_MINUS;
            len        <= calc_neg ? LW'(1) : LW'(0);
            pidx       <= PW'(MAX_DIGITS - 1);
            dig        <= '0;
            started    <= 1'b0;
            state      <= S_CONV;
          end
        end
        S_CONV: begin
          if (rem >= p_cur) begin
            rem <= rem - p_cur;
            dig <= dig + 4'd1;
          end else begin
            dig <= '0;
            if (pidx == '0) begin
              // Units digit is always emitted so a zero result still prints "0"
              out_buf[li]          <= dig_ch;
              out_buf[li + IW'(1)] <= CH_CR;
              out_buf[li + IW'(2)] <= CH_LF;
              len                  <= len + LW'(3);
              state                <= S_SEND;
            end else begin
              if ((dig != '0) || started) begin
                out_buf[li] <= dig_ch;
                len         <= len + LW'(1);
                started     <= 1'b1;
              end
              pidx <= pidx - PW'(1);
            end
          end
        end
        S_SEND: begin
          if (!tx_valid) begin
            tx_data  <= out_buf[idx[IW-1:0]];
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            if (idx == len - LW'(1)) begin
              a_reg <= '0;
              b_reg <= '0;
              cnt_a <= '0;
              cnt_b <= '0;
              busy  <= 1'b0;
              state <= S_ACC_A;
            end else begin
              idx <= idx + LW'(1);
            end
          end
        end
        default: state <= S_ACC_A;
      endcase
    end
  end

endmodule
